mem_lsu: RTL and testbench

- MEM-stage load/store unit. Consumes the MEM-stage control and data signals (`mem_write_MEM`, `result_sel_MEM`, `alu_res_MEM`, `write_data_MEM`, `funct3_MEM`).
- Runs a valid/ready transaction with data memory and stalls the pipeline until the access completes.
- Byte-lane aligns store data and sign/zero-extends load data into `read_data_MEM`, which feeds MEM/WB.

---
 rtl/mem_lsu.sv | 132 +++++++++++++
 tb/tb_mem_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Drives a valid/ready data-memory transaction, stalls the pipeline while the
// access is in flight, lane-aligns store data and extends load data.
module mem_lsu #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_MEM,
  input  logic                       mem_write_MEM,
  input  logic [1:0]                 result_sel_MEM,
  input  logic [DATA_ADDR_WIDTH-1:0] alu_res_MEM,
  input  logic [DATA_WIDTH-1:0]      write_data_MEM,
  input  logic [2:0]                 funct3_MEM,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  input  logic                       dmem_ready,
  input  logic                       dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  output logic [DATA_WIDTH-1:0]      read_data_MEM,
  output logic                       stall_MEM,
  output logic                       misalign_MEM
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [1:0]              lat_off;
  logic [2:0]              lat_funct3;

  logic                    is_store;
  logic                    is_load;
  logic                    access;
  logic                    misaligned;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Decode the MEM-stage op; a store flag wins when both store and load are set.
  always_comb begin
    is_store = mem_write_MEM;
    is_load  = ~mem_write_MEM & (result_sel_MEM == 2'b01);
    access   = valid_MEM & (is_store | is_load);
    case (funct3_MEM[1:0])
      2'b01:   misaligned = alu_res_MEM[0];
      2'b10:   misaligned = (alu_res_MEM[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    misalign_MEM = access & misaligned;
    issue        = (state == S_IDLE) & access & ~misaligned & ~rst;
    stall_MEM    = issue | ((state == S_WAIT) & ~rst);
  end

  // Request outputs are only non-zero while a request is actually being offered.
  always_comb begin
    dmem_req   = issue;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = 4'b0000;
    if (issue) begin
      dmem_we   = is_store;
      dmem_addr = {alu_res_MEM[DATA_ADDR_WIDTH-1:2], 2'b00};
      if (is_store) begin
        case (funct3_MEM[1:0])
          2'b00: begin
            dmem_wstrb = 4'b0001 << alu_res_MEM[1:0];
            dmem_wdata = {4{write_data_MEM[7:0]}};
          end
          2'b01: begin
            dmem_wstrb = 4'b0011 << alu_res_MEM[1:0];
            dmem_wdata = {2{write_data_MEM[15:0]}};
          end
          default: begin
            dmem_wstrb = 4'b1111;
            dmem_wdata = write_data_MEM;
          end
        endcase
      end
    end
  end

  // Extract the addressed byte/halfword using the op latched at acceptance.
  always_comb begin
    shifted = dmem_rdata >> {lat_off, 3'b000};
    case (lat_funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Transaction FSM: accept in IDLE, wait for load data, then release for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_off       <= 2'b00;
      lat_funct3    <= 3'b000;
      read_data_MEM <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue && dmem_ready) begin
            lat_off    <= alu_res_MEM[1:0];
            lat_funct3 <= funct3_MEM;
            state      <= is_store ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            read_data_MEM <= load_ext;
            state         <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for the MEM-stage load/store unit.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_MEM;
  logic        mem_write_MEM;
  logic [1:0]  result_sel_MEM;
  logic [31:0] alu_res_MEM;
  logic [31:0] write_data_MEM;
  logic [2:0]  funct3_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_MEM;
  logic        stall_MEM;
  logic        misalign_MEM;

  int checks = 0;
  int passes = 0;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .valid_MEM      (valid_MEM),
    .mem_write_MEM  (mem_write_MEM),
    .result_sel_MEM (result_sel_MEM),
    .alu_res_MEM    (alu_res_MEM),
    .write_data_MEM (write_data_MEM),
    .funct3_MEM     (funct3_MEM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ready     (dmem_ready),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .read_data_MEM  (read_data_MEM),
    .stall_MEM      (stall_MEM),
    .misalign_MEM   (misalign_MEM)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] rs,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [2:0] f3);
    valid_MEM      = v;
    mem_write_MEM  = we;
    result_sel_MEM = rs;
    alu_res_MEM    = addr;
    write_data_MEM = wd;
    funct3_MEM     = f3;
  endtask

  // Store with ready high: one request/stall cycle, then DONE, then back in IDLE.
  task automatic runStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                          input logic [3:0] exp_strb, input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b1, 2'b00, addr, wd, f3);
    dmem_ready = 1'b1;
    #1;
    checkOutput("st_req",   {31'b0, dmem_req},   32'd1);
    checkOutput("st_we",    {31'b0, dmem_we},    32'd1);
    checkOutput("st_addr",  dmem_addr,           {addr[31:2], 2'b00});
    checkOutput("st_wstrb", {28'b0, dmem_wstrb}, {28'b0, exp_strb});
    checkOutput("st_wdata", dmem_wdata,          exp_data);
    checkOutput("st_stall", {31'b0, stall_MEM},  32'd1);
    @(negedge clk);
    dmem_ready = 1'b0;
    checkOutput("st_done_stall", {31'b0, stall_MEM}, 32'd0);
    checkOutput("st_done_req",   {31'b0, dmem_req},  32'd0);
    @(negedge clk);
  endtask

  // Load accepted immediately, rvalid the cycle after; inputs change mid-flight.
  task automatic runLoad(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, 2'b01, addr, 32'h0, f3);
    dmem_ready = 1'b1;
    #1;
    checkOutput("ld_req",   {31'b0, dmem_req},  32'd1);
    checkOutput("ld_we",    {31'b0, dmem_we},   32'd0);
    checkOutput("ld_addr",  dmem_addr,          {addr[31:2], 2'b00});
    checkOutput("ld_stall", {31'b0, stall_MEM}, 32'd1);
    @(negedge clk);
    dmem_ready = 1'b0;
    checkOutput("ld_wait_stall", {31'b0, stall_MEM}, 32'd1);
    checkOutput("ld_wait_req",   {31'b0, dmem_req},  32'd0);
    alu_res_MEM = {addr[31:2], 2'b00};
    funct3_MEM  = 3'b010;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("ld_data",       read_data_MEM,      exp);
    checkOutput("ld_done_stall", {31'b0, stall_MEM}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000);
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req",   {31'b0, dmem_req},     32'd0);
    checkOutput("rst_stall", {31'b0, stall_MEM},    32'd0);
    checkOutput("rst_rdata", read_data_MEM,         32'd0);
    checkOutput("rst_wstrb", {28'b0, dmem_wstrb},   32'd0);
    checkOutput("rst_addr",  dmem_addr,             32'd0);
    rst = 1'b0;
    @(negedge clk);

    runStore(32'h0000_1003, 3'b000, 32'hAABB_CCDD, 4'b1000, 32'hDDDD_DDDD);
    runStore(32'h0000_1002, 3'b001, 32'h5678_1234, 4'b1100, 32'h1234_1234);
    runStore(32'h0000_1000, 3'b010, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);

    runLoad(32'h0000_2001, 3'b000, 32'h1234_80FF, 32'hFFFF_FF80);
    runLoad(32'h0000_2001, 3'b100, 32'h1234_80FF, 32'h0000_0080);
    runLoad(32'h0000_2002, 3'b001, 32'h8000_1234, 32'hFFFF_8000);
    runLoad(32'h0000_2002, 3'b101, 32'h8000_1234, 32'h0000_8000);
    runLoad(32'h0000_2000, 3'b001, 32'h8000_1234, 32'h0000_1234);
    runLoad(32'h0000_2004, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // LW with ready held low for three cycles
    applyStimulus(1'b1, 1'b0, 2'b01, 32'h0000_4000, 32'h0, 3'b010);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("lw_hold_req",   {31'b0, dmem_req},  32'd1);
      checkOutput("lw_hold_addr",  dmem_addr,          32'h0000_4000);
      checkOutput("lw_hold_stall", {31'b0, stall_MEM}, 32'd1);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    checkOutput("lw_accept_req", {31'b0, dmem_req}, 32'd1);
    @(negedge clk);
    dmem_ready = 1'b1;
    checkOutput("lw_wait1_stall", {31'b0, stall_MEM}, 32'd1);
    checkOutput("lw_wait1_req",   {31'b0, dmem_req},  32'd0);
    @(negedge clk);
    dmem_ready = 1'b0;
    checkOutput("lw_wait2_stall", {31'b0, stall_MEM}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_BABE;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("lw_data",       read_data_MEM,      32'hCAFE_BABE);
    checkOutput("lw_done_stall", {31'b0, stall_MEM}, 32'd0);
    @(negedge clk);

    // Misaligned accesses: no request, no stall, stray rvalid ignored
    applyStimulus(1'b1, 1'b0, 2'b01, 32'h0000_3001, 32'h0, 3'b001);
    dmem_ready  = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_0000;
    #1;
    checkOutput("lh_mis_flag",  {31'b0, misalign_MEM}, 32'd1);
    checkOutput("lh_mis_req",   {31'b0, dmem_req},     32'd0);
    checkOutput("lh_mis_stall", {31'b0, stall_MEM},    32'd0);
    @(negedge clk);
    checkOutput("lh_mis_rdata", read_data_MEM, 32'hCAFE_BABE);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_3002, 32'h1111_2222, 3'b010);
    #1;
    checkOutput("sw_mis_flag",  {31'b0, misalign_MEM}, 32'd1);
    checkOutput("sw_mis_req",   {31'b0, dmem_req},     32'd0);
    checkOutput("sw_mis_stall", {31'b0, stall_MEM},    32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("sw_mis_rdata", read_data_MEM, 32'hCAFE_BABE);

    // Reset while a load waits for data; late rvalid must be dropped
    applyStimulus(1'b1, 1'b0, 2'b01, 32'h0000_5000, 32'h0, 3'b010);
    dmem_ready = 1'b1;
    #1;
    checkOutput("rstw_req", {31'b0, dmem_req}, 32'd1);
    @(negedge clk);
    dmem_ready = 1'b0;
    checkOutput("rstw_wait_stall", {31'b0, stall_MEM}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstw_rdata", read_data_MEM,      32'd0);
    checkOutput("rstw_stall", {31'b0, stall_MEM}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("rstw_late_rdata", read_data_MEM,      32'd0);
    checkOutput("rstw_late_stall", {31'b0, stall_MEM}, 32'd0);
    checkOutput("rstw_late_req",   {31'b0, dmem_req},  32'd0);

    // Bubbles never request, stall or flag misalignment
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_1000, 32'h55, 3'b010);
    dmem_ready = 1'b1;
    #1;
    checkOutput("bub_req",   {31'b0, dmem_req},  32'd0);
    checkOutput("bub_stall", {31'b0, stall_MEM}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b01, 32'h0000_1001, 32'h0, 3'b010);
    #1;
    checkOutput("bub_mis", {31'b0, misalign_MEM}, 32'd0);
    @(negedge clk);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
